// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared UART definitions. The transmitter uses them now, and the future
//   uart_rx will use them as well.
//   - uart_state_t : 3-bit frame state encoding, ST_IDLE..ST_STOP
//   - PAR_*        : codes for the PARITY parameter
//   - calc_parity  : computes the parity bit for a data word
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // The caller passes the data word zero-extended to 8 bits. Zero padding
  // does not change the XOR. Even parity makes the total count of ones
  // even. Odd parity makes it odd.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// uart_baud_tick
//   Bit-period counter for the UART. It counts 0..CLKS_PER_BIT-1 while
//   enabled and raises tick on the terminal count. After that it wraps,
//   so several periods can run back-to-back.
//   Ports:
//     i_clk    : system clock
//     i_rst    : synchronous active-high reset
//     i_clear  : forces the count to 0 (asserted on state changes)
//     i_enable : count while high
//     o_tick   : high during the last cycle of a bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count;

  assign o_tick = i_enable && (count == CNT_W'(CLKS_PER_BIT - 1));

  // A clear has priority over counting, so every new state starts a fresh
  // period regardless of where the previous one ended.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= o_tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
//   UART transmitter that drains a first-word-fall-through byte FIFO.
//   When the line is idle and the FIFO is non-empty, it pops one word and
//   sends it as: start bit, data bits LSB first, optional parity bit,
//   then stop bit(s).
//   Ports:
//     i_clk        : system clock
//     i_rst        : synchronous active-high reset
//     i_fifo_empty : FIFO empty flag
//     i_fifo_data  : FIFO head word, valid while i_fifo_empty=0
//     o_fifo_rd    : combinational pop strobe, one cycle per word
//     o_tx         : registered serial line, idle high
//     o_busy       : registered, high for the whole active frame
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fifo_empty,
  input  logic [DATA_BITS-1:0] i_fifo_data,
  output logic                 o_fifo_rd,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int IDX_W = 3;

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 parity_reg, parity_next;
  logic                 tx_next, busy_next;
  logic                 bit_tick;
  logic [7:0]           data_ext;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (state_next != state),
    .i_enable (state != ST_IDLE),
    .o_tick   (bit_tick)
  );

  // Zero-extend the head word so the parity helper always sees 8 bits.
  always_comb begin
    data_ext = '0;
    data_ext[DATA_BITS-1:0] = i_fifo_data;
  end

  assign o_fifo_rd = (state == ST_IDLE) && !i_fifo_empty && !i_rst;

  // Next-state logic. o_tx and o_busy are registered, so their next values
  // are computed here together with the state. Each transition sets the
  // line level for the state it enters.
  always_comb begin
    state_next    = state;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    parity_next   = parity_reg;
    tx_next       = o_tx;
    busy_next     = o_busy;

    case (state)
      ST_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (o_fifo_rd) begin
          shift_next  = i_fifo_data;
          parity_next = calc_parity(data_ext, PARITY);
          state_next  = ST_START;
          tx_next     = 1'b0;
          busy_next   = 1'b1;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY == PAR_NONE) begin
              state_next    = ST_STOP;
              stop_cnt_next = 1'b0;
              tx_next       = 1'b1;
            end else begin
              state_next = ST_PARITY;
              tx_next    = parity_reg;
            end
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            tx_next      = shift_reg[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          state_next    = ST_STOP;
          stop_cnt_next = 1'b0;
          tx_next       = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State register. Reset aborts any frame in flight and drops its byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      parity_reg <= 1'b0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_idx    <= bit_idx_next;
      stop_cnt   <= stop_cnt_next;
      parity_reg <= parity_next;
      o_tx       <= tx_next;
      o_busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
//   Runs three transmitters side by side on the same stimulus:
//     0: no parity,   1 stop bit
//     1: even parity, 2 stop bits
//     2: odd parity,  1 stop bit
//   All use 4 clocks per bit and 8 data bits. Each transmitter has its own
//   FIFO. A frame-level reference model predicts the line, busy and pop
//   strobe for every cycle.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int NDUT = 3;
  localparam int MEMSZ = 256;

  logic clk;
  logic rst;
  logic [NDUT-1:0] fifoEmpty;
  logic [7:0] fifoData [NDUT];
  logic [NDUT-1:0] fifoRd;
  logic [NDUT-1:0] tx;
  logic [NDUT-1:0] busy;

  logic [7:0] fifoMem [NDUT][MEMSZ];
  int envHead [NDUT];
  int envTail [NDUT];
  logic popPending [NDUT];

  int mE [NDUT];
  int mLen [NDUT];
  int mHead [NDUT];
  logic [11:0] mFrame [NDUT];

  int checkCount;
  int passCount;
  int cycleNum;
  int busyCount [NDUT];
  int popCount0;
  int lastPop0;
  int prevPop0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_fifo_empty(fifoEmpty[0]), .i_fifo_data(fifoData[0]),
    .o_fifo_rd(fifoRd[0]), .o_tx(tx[0]), .o_busy(busy[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_fifo_empty(fifoEmpty[1]), .i_fifo_data(fifoData[1]),
    .o_fifo_rd(fifoRd[1]), .o_tx(tx[1]), .o_busy(busy[1]));

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_fifo_empty(fifoEmpty[2]), .i_fifo_data(fifoData[2]),
    .o_fifo_rd(fifoRd[2]), .o_tx(tx[2]), .o_busy(busy[2]));

  always #5 clk = ~clk;

  function automatic int parOf(input int d);
    return (d == 1) ? 2 : ((d == 2) ? 1 : 0);
  endfunction

  function automatic int stopOf(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int frameCycles(input int d);
    return (1 + 8 + ((parOf(d) != 0) ? 1 : 0) + stopOf(d)) * CPB;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Builds the list of bits the model expects for one byte. Each list entry
  // is held on the line for CPB cycles.
  task automatic buildFrame(input int d, input logic [7:0] b);
    logic [11:0] f;
    int n;
    f = '1;
    n = 0;
    f[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      f[n] = b[i];
      n++;
    end
    if (parOf(d) != 0) begin
      f[n] = (parOf(d) == 2) ? (^b) : ~(^b);
      n++;
    end
    for (int s = 0; s < stopOf(d); s++) begin
      f[n] = 1'b1;
      n++;
    end
    mFrame[d] = f;
    mLen[d] = n * CPB;
  endtask

  // One clock cycle. Inputs change on the falling edge, the outputs are
  // checked 1 time unit later, and then the model steps to the next cycle.
  task automatic applyStimulus(input logic rstVal, input logic doPush, input logic [7:0] pushByte);
    logic expTx, expBusy, expRd;
    @(negedge clk);
    cycleNum++;
    for (int d = 0; d < NDUT; d++) if (popPending[d]) envHead[d]++;
    rst = rstVal;
    if (doPush) begin
      for (int d = 0; d < NDUT; d++) begin
        fifoMem[d][envTail[d] % MEMSZ] = pushByte;
        envTail[d]++;
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      fifoEmpty[d] = (envHead[d] == envTail[d]);
      fifoData[d] = fifoMem[d][envHead[d] % MEMSZ];
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (mE[d] >= 0) begin
        expTx = mFrame[d][mE[d] / CPB];
        expBusy = 1'b1;
        expRd = 1'b0;
      end else begin
        expTx = 1'b1;
        expBusy = 1'b0;
        expRd = !rstVal && (mHead[d] != envTail[d]);
      end
      checkOutput($sformatf("d%0d.tx@%0d", d, cycleNum), 32'(tx[d]), 32'(expTx));
      checkOutput($sformatf("d%0d.busy@%0d", d, cycleNum), 32'(busy[d]), 32'(expBusy));
      checkOutput($sformatf("d%0d.rd@%0d", d, cycleNum), 32'(fifoRd[d]), 32'(expRd));
      popPending[d] = (fifoRd[d] === 1'b1);
      if (busy[d] === 1'b1) busyCount[d]++;
      if (d == 0 && fifoRd[0] === 1'b1) begin
        popCount0++;
        prevPop0 = lastPop0;
        lastPop0 = cycleNum;
      end
      if (rstVal) begin
        mE[d] = -1;
      end else if (mE[d] >= 0) begin
        mE[d]++;
        if (mE[d] == mLen[d]) mE[d] = -1;
      end else if (expRd) begin
        buildFrame(d, fifoMem[d][mHead[d] % MEMSZ]);
        mHead[d]++;
        mE[d] = 0;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clearCounters();
    for (int d = 0; d < NDUT; d++) busyCount[d] = 0;
    popCount0 = 0;
  endtask

  initial begin
    int guard;
    int txHigh;
    clk = 0;
    rst = 1;
    fifoEmpty = '1;
    checkCount = 0;
    passCount = 0;
    cycleNum = 0;
    lastPop0 = 0;
    prevPop0 = 0;
    for (int d = 0; d < NDUT; d++) begin
      fifoData[d] = 8'h00;
      envHead[d] = 0;
      envTail[d] = 0;
      popPending[d] = 1'b0;
      mE[d] = -1;
      mLen[d] = 0;
      mHead[d] = 0;
      mFrame[d] = '1;
      for (int i = 0; i < MEMSZ; i++) fifoMem[d][i] = 8'h00;
    end
    clearCounters();
    @(posedge clk);

    $display("[TB] reset with empty FIFO");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'h00);

    $display("[TB] single byte 0x35");
    clearCounters();
    applyStimulus(1'b0, 1'b1, 8'h35);
    idleCycles(59);
    for (int d = 0; d < NDUT; d++)
      checkOutput($sformatf("d%0d.busyLen35", d), 32'(busyCount[d]), 32'(frameCycles(d)));
    checkOutput("popCount35", 32'(popCount0), 32'd1);

    $display("[TB] back-to-back 0x0A 0x2B");
    clearCounters();
    applyStimulus(1'b0, 1'b1, 8'h0A);
    applyStimulus(1'b0, 1'b1, 8'h2B);
    idleCycles(110);
    checkOutput("popCount0A2B", 32'(popCount0), 32'd2);
    checkOutput("popGap", 32'(lastPop0 - prevPop0), 32'(frameCycles(0) + 1));

    $display("[TB] parity byte 0x07");
    clearCounters();
    applyStimulus(1'b0, 1'b1, 8'h07);
    idleCycles(60);
    for (int d = 0; d < NDUT; d++)
      checkOutput($sformatf("d%0d.busyLen07", d), 32'(busyCount[d]), 32'(frameCycles(d)));

    $display("[TB] reset during data bit 3");
    applyStimulus(1'b0, 1'b1, 8'h55);
    applyStimulus(1'b0, 1'b1, 8'h66);
    guard = 0;
    while (mE[0] != 17 && guard < 200) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      guard++;
    end
    checkOutput("reachBit3", 32'(guard < 200), 32'd1);
    clearCounters();
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("popAfterRelease", 32'(popCount0), 32'd1);
    idleCycles(60);
    checkOutput("popCountAfterReset", 32'(popCount0), 32'd1);

    $display("[TB] empty FIFO for 100 cycles");
    clearCounters();
    txHigh = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (tx[0] === 1'b1) txHigh++;
    end
    checkOutput("idlePops", 32'(popCount0), 32'd0);
    checkOutput("idleTxHigh", 32'(txHigh), 32'd100);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      logic doRst, doPush;
      doRst = ($urandom_range(0, 499) == 0);
      doPush = ($urandom_range(0, 39) == 0) && ((envTail[0] - envHead[0]) < MEMSZ - 8);
      applyStimulus(doRst, doPush, 8'($urandom_range(0, 255)));
    end

    guard = 0;
    while (guard < 3000 && !(mE[0] < 0 && mE[1] < 0 && mE[2] < 0 &&
           mHead[0] == envTail[0] && mHead[1] == envTail[1] && mHead[2] == envTail[2])) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      guard++;
    end
    checkOutput("drainInTime", 32'(guard < 3000), 32'd1);
    idleCycles(2);
    checkOutput("drainBusy", 32'(busy), 32'd0);
    checkOutput("drainTx", 32'(tx), 32'd7);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
